// File: rtl/alu_sliced.sv
// Multi-cycle ALU that evaluates its 74181-style function 8 bits per clock,
// chaining the carry from slice to slice and publishing all outputs at once.
module alu_sliced #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        sel,
  input  logic              mode,
  input  logic              cf_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              cf_out,
  output logic              zf,
  output logic              sf
);

  localparam int unsigned NSLICE = DATA_W / 8;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned OFF_W  = IDX_W + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_sel;
  logic              r_mode;
  logic              r_c;
  logic [DATA_W-1:0] r_acc;

  logic [1:0]        w_state_nxt;
  logic [OFF_W-1:0]  w_off;
  logic [7:0]        w_sa;
  logic [7:0]        w_sb;
  logic [7:0]        w_logic;
  logic [7:0]        w_x;
  logic [7:0]        w_y;
  logic [8:0]        w_sum;
  logic [7:0]        w_res8;
  logic              w_cout;
  logic [DATA_W-1:0] w_full;
  logic              w_last;
  logic              w_load;
  logic              w_fin;

  assign w_off  = {r_idx, 3'b000};
  assign w_sa   = r_a[w_off +: 8];
  assign w_sb   = r_b[w_off +: 8];
  assign w_last = (r_idx == IDX_W'(NSLICE - 1));
  assign w_load = (r_state != S_RUN) && start;
  assign w_fin  = (r_state == S_RUN) && w_last;

  // One slice of the function; arithmetic ops are always X + Y + carry.
  always_comb begin
    w_logic = '0;
    w_x     = '0;
    w_y     = '0;
    case (r_sel)
      4'd0:  w_logic = ~w_sa;
      4'd1:  w_logic = ~(w_sa | w_sb);
      4'd2:  w_logic = ~w_sa & w_sb;
      4'd3:  w_logic = 8'h00;
      4'd4:  w_logic = ~(w_sa & w_sb);
      4'd5:  w_logic = ~w_sb;
      4'd6:  w_logic = w_sa ^ w_sb;
      4'd7:  w_logic = w_sa & ~w_sb;
      4'd8:  w_logic = ~w_sa | w_sb;
      4'd9:  w_logic = ~(w_sa ^ w_sb);
      4'd10: w_logic = w_sb;
      4'd11: w_logic = w_sa & w_sb;
      4'd12: w_logic = 8'hFF;
      4'd13: w_logic = w_sa | ~w_sb;
      4'd14: w_logic = w_sa | w_sb;
      default: w_logic = w_sa;
    endcase
    case (r_sel)
      4'd0:  begin w_x = w_sa;           w_y = 8'h00;          end
      4'd1:  begin w_x = w_sa | w_sb;    w_y = 8'h00;          end
      4'd2:  begin w_x = w_sa | ~w_sb;   w_y = 8'h00;          end
      4'd3:  begin w_x = 8'hFF;          w_y = 8'h00;          end
      4'd4:  begin w_x = w_sa;           w_y = w_sa & ~w_sb;   end
      4'd5:  begin w_x = w_sa | w_sb;    w_y = w_sa & ~w_sb;   end
      4'd6:  begin w_x = w_sa;           w_y = ~w_sb;          end
      4'd7:  begin w_x = w_sa & ~w_sb;   w_y = 8'hFF;          end
      4'd8:  begin w_x = w_sa;           w_y = w_sa & w_sb;    end
      4'd9:  begin w_x = w_sa;           w_y = w_sb;           end
      4'd10: begin w_x = w_sa | ~w_sb;   w_y = w_sa & w_sb;    end
      4'd11: begin w_x = w_sa & w_sb;    w_y = 8'hFF;          end
      4'd12: begin w_x = w_sa;           w_y = w_sa;           end
      4'd13: begin w_x = w_sa | w_sb;    w_y = w_sa;           end
      4'd14: begin w_x = w_sa | ~w_sb;   w_y = w_sa;           end
      default: begin w_x = w_sa;         w_y = 8'hFF;          end
    endcase
    w_sum  = 9'(w_x) + 9'(w_y) + 9'(r_c);
    w_res8 = r_mode ? w_logic : w_sum[7:0];
    w_cout = r_mode ? 1'b0 : w_sum[8];
    w_full = r_acc;
    w_full[w_off +: 8] = w_res8;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_mode  <= 1'b0;
      r_c     <= 1'b0;
      r_acc   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cf_out  <= 1'b0;
      zf      <= 1'b1;
      sf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == S_RUN);
      done    <= (w_state_nxt == S_DONE);
      if (w_load) begin
        r_a    <= a;
        r_b    <= b;
        r_sel  <= sel;
        r_mode <= mode;
        r_c    <= cf_in;
        r_idx  <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= w_full;
        r_c   <= w_cout;
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
      // Visible outputs move only when the final slice lands.
      if (w_fin) begin
        result <= w_full;
        cf_out <= w_cout;
        zf     <= (w_full == '0);
        sf     <= w_full[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_sliced.sv
// Bench for alu_sliced: 16- and 32-bit instances checked against a
// full-width arithmetic model of the function table.
module tb_alu_sliced;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16;
  logic        start32;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  logic        mode;
  logic        cf_in;

  logic        busy16, done16, cf16, zf16, sf16;
  logic [15:0] res16;
  logic        busy32, done32, cf32, zf32, sf32;
  logic [31:0] res32;

  int checks   = 0;
  int failures = 0;
  logic [31:0] prev16 = '0;
  logic [31:0] prev32 = '0;

  always #5 clk = ~clk;

  alu_sliced #(.DATA_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a[15:0]), .b(b[15:0]),
    .sel(sel), .mode(mode), .cf_in(cf_in), .busy(busy16), .done(done16),
    .result(res16), .cf_out(cf16), .zf(zf16), .sf(sf16)
  );

  alu_sliced #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a), .b(b),
    .sel(sel), .mode(mode), .cf_in(cf_in), .busy(busy32), .done(done32),
    .result(res32), .cf_out(cf32), .zf(zf32), .sf(sf32)
  );

  // Returns {carry, result} for a w-bit operation.
  function automatic logic [32:0] model(int unsigned w, logic [31:0] av, logic [31:0] bv,
                                        logic [3:0] s, logic m, logic c);
    logic [32:0] msk, aa, bb, na, nb, x, y, sum, lr;
    msk = (33'd1 << w) - 33'd1;
    aa  = {1'b0, av} & msk;
    bb  = {1'b0, bv} & msk;
    na  = ~aa & msk;
    nb  = ~bb & msk;
    lr  = '0;
    x   = '0;
    y   = '0;
    if (m) begin
      case (s)
        4'd0:  lr = na;
        4'd1:  lr = ~(aa | bb);
        4'd2:  lr = na & bb;
        4'd3:  lr = '0;
        4'd4:  lr = ~(aa & bb);
        4'd5:  lr = nb;
        4'd6:  lr = aa ^ bb;
        4'd7:  lr = aa & nb;
        4'd8:  lr = na | bb;
        4'd9:  lr = ~(aa ^ bb);
        4'd10: lr = bb;
        4'd11: lr = aa & bb;
        4'd12: lr = msk;
        4'd13: lr = aa | nb;
        4'd14: lr = aa | bb;
        default: lr = aa;
      endcase
      return {1'b0, lr[31:0] & msk[31:0]};
    end
    case (s)
      4'd0:  begin x = aa;        y = '0;      end
      4'd1:  begin x = aa | bb;   y = '0;      end
      4'd2:  begin x = aa | nb;   y = '0;      end
      4'd3:  begin x = msk;       y = '0;      end
      4'd4:  begin x = aa;        y = aa & nb; end
      4'd5:  begin x = aa | bb;   y = aa & nb; end
      4'd6:  begin x = aa;        y = nb;      end
      4'd7:  begin x = aa & nb;   y = msk;     end
      4'd8:  begin x = aa;        y = aa & bb; end
      4'd9:  begin x = aa;        y = bb;      end
      4'd10: begin x = aa | nb;   y = aa & bb; end
      4'd11: begin x = aa & bb;   y = msk;     end
      4'd12: begin x = aa;        y = aa;      end
      4'd13: begin x = aa | bb;   y = aa;      end
      4'd14: begin x = aa | nb;   y = aa;      end
      default: begin x = aa;      y = msk;     end
    endcase
    sum = x + y + 33'(c);
    return {sum[w], sum[31:0] & msk[31:0]};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_busy(int unsigned w); return (w == 16) ? busy16 : busy32; endfunction
  function automatic logic o_done(int unsigned w); return (w == 16) ? done16 : done32; endfunction
  function automatic logic o_cf(int unsigned w);   return (w == 16) ? cf16 : cf32;     endfunction
  function automatic logic o_zf(int unsigned w);   return (w == 16) ? zf16 : zf32;     endfunction
  function automatic logic o_sf(int unsigned w);   return (w == 16) ? sf16 : sf32;     endfunction
  function automatic logic [31:0] o_res(int unsigned w);
    return (w == 16) ? 32'(res16) : res32;
  endfunction

  // One operation with junk inputs and stray start pulses during RUN.
  task automatic run_op(int unsigned w, logic [31:0] av, logic [31:0] bv, logic [3:0] s,
                        logic m, logic c, string tag);
    int unsigned n;
    logic [32:0] e;
    logic [31:0] prev;
    n    = w / 8;
    e    = model(w, av, bv, s, m, c);
    prev = (w == 16) ? prev16 : prev32;
    @(negedge clk);
    a = av; b = bv; sel = s; mode = m; cf_in = c;
    if (w == 16) start16 = 1'b1; else start32 = 1'b1;
    for (int i = 1; i <= int'(n) + 1; i++) begin
      @(negedge clk);
      start16 = 1'b0; start32 = 1'b0;
      a = $urandom; b = $urandom; sel = 4'($urandom); mode = 1'($urandom); cf_in = 1'($urandom);
      if (i <= int'(n)) begin
        check($sformatf("%s_busy%0d", tag, i), 64'(o_busy(w)), 64'd1);
        check($sformatf("%s_done%0d", tag, i), 64'(o_done(w)), 64'd0);
        check($sformatf("%s_hold%0d", tag, i), 64'(o_res(w)), 64'(prev));
        if (w == 16) start16 = 1'($urandom); else start32 = 1'($urandom);
      end else begin
        check({tag, "_done"}, 64'(o_done(w)), 64'd1);
        check({tag, "_busy"}, 64'(o_busy(w)), 64'd0);
        check({tag, "_res"},  64'(o_res(w)), 64'(e[31:0]));
        check({tag, "_cf"},   64'(o_cf(w)), 64'(e[32]));
        check({tag, "_zf"},   64'(o_zf(w)), 64'(e[31:0] == 32'd0));
        check({tag, "_sf"},   64'(o_sf(w)), 64'(e[w-1]));
      end
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(o_busy(w)), 64'd0);
    check({tag, "_idle_done"}, 64'(o_done(w)), 64'd0);
    check({tag, "_idle_res"},  64'(o_res(w)), 64'(e[31:0]));
    if (w == 16) prev16 = e[31:0]; else prev32 = e[31:0];
  endtask

  initial begin
    logic [32:0] e;
    rst = 1'b1; start16 = 1'b0; start32 = 1'b0;
    a = '0; b = '0; sel = '0; mode = 1'b0; cf_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy16), 64'd0);
    check("rst_done", 64'(done16), 64'd0);
    check("rst_res",  64'(res16), 64'd0);
    check("rst_cf",   64'(cf16), 64'd0);
    check("rst_zf",   64'(zf16), 64'd1);
    check("rst_sf",   64'(sf16), 64'd0);
    check("rst_res32", 64'(res32), 64'd0);

    // Directed cases with hand-derived results.
    run_op(16, 32'h00FF, 32'h0001, 4'd9, 1'b0, 1'b0, "add");
    check("add_const", 64'(res16), 64'h0100);
    run_op(16, 32'h0000, 32'h0001, 4'd6, 1'b0, 1'b1, "sub0");
    check("sub0_const", 64'({cf16, sf16, res16}), 64'({1'b0, 1'b1, 16'hFFFF}));
    run_op(16, 32'h0005, 32'h0001, 4'd6, 1'b0, 1'b1, "sub5");
    check("sub5_const", 64'({cf16, res16}), 64'({1'b1, 16'h0004}));
    run_op(16, 32'hF0F0, 32'hFFFF, 4'd6, 1'b1, 1'b1, "xor");
    check("xor_const", 64'({cf16, res16}), 64'({1'b0, 16'h0F0F}));
    run_op(16, 32'h1234, 32'h5678, 4'd3, 1'b1, 1'b0, "zero");
    check("zero_const", 64'({zf16, res16}), 64'({1'b1, 16'h0000}));
    run_op(32, 32'hFFFF_FFFF, 32'h0, 4'd9, 1'b0, 1'b1, "wrap32");
    check("wrap32_const", 64'({cf32, zf32, res32}), 64'({1'b1, 1'b1, 32'h0}));

    // Randomised operations on both widths.
    for (int k = 0; k < 30; k++)
      run_op(16, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), $sformatf("r16_%0d", k));
    for (int k = 0; k < 10; k++)
      run_op(32, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), $sformatf("r32_%0d", k));

    // Start held high: a done pulse every third cycle.
    e = model(16, 32'h1234, 32'h0F0F, 4'd9, 1'b0, 1'b1);
    @(negedge clk);
    a = 32'h1234; b = 32'h0F0F; sel = 4'd9; mode = 1'b0; cf_in = 1'b1; start16 = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check($sformatf("b2b_done%0d", j), 64'(done16), 64'(j % 3 == 0));
      check($sformatf("b2b_busy%0d", j), 64'(busy16), 64'(j % 3 != 0));
      if (j % 3 == 0) check($sformatf("b2b_res%0d", j), 64'(res16), 64'(e[15:0]));
      if (j == 9) start16 = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", 64'({busy16, done16}), 64'd0);

    // Reset mid-RUN aborts with no done pulse and no result update.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_res", 64'(res16), 64'd0);
    a = 32'h00FF; b = 32'h0001; sel = 4'd9; mode = 1'b0; cf_in = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    check("abort_busy_run", 64'(busy16), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy16), 64'd0);
    check("abort_done", 64'(done16), 64'd0);
    check("abort_res",  64'(res16), 64'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("abort_after%0d", j), 64'({busy16, done16, res16}), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sliced.md
ALU_SLICED -- requirements
Module: alu_sliced

Interface
REQ-001 SHALL have parameter DATA_W, default 16: operand/result width in bits, a multiple of 8 and at least 8.
REQ-002 SHALL have localparam NSLICE = DATA_W/8: number of 8-bit slices per operation.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled on the rising edge.
REQ-006 SHALL have ports a and b, input, DATA_W bits each: operands.
REQ-007 SHALL have port sel, input, 4 bits: function select.
REQ-008 SHALL have port mode, input, 1 bit: 1 selects a logic function, 0 selects an arithmetic function.
REQ-009 SHALL have port cf_in, input, 1 bit: carry-in, active-high.
REQ-010 SHALL have port busy, output, 1 bit: high while slices are being computed.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port result, output, DATA_W bits: last completed result.
REQ-013 SHALL have ports cf_out, zf and sf, output, 1 bit each: carry-out, zero flag and sign flag of the last completed result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE or DONE with start=1, latch a, b, sel, mode and cf_in, clear the slice index to 0 and enter RUN.
REQ-016 SHALL ignore start while in RUN; the latched inputs SHALL NOT change until the operation completes.
REQ-017 SHALL, on each RUN edge, compute slice k (bits 8k+7..8k) of the latched operands, store it internally, propagate carry to slice k+1 and increment k.
REQ-018 SHALL use cf_in as the carry into slice 0.
REQ-019 SHALL, on the edge that computes slice NSLICE-1, load result, cf_out, zf and sf together and enter DONE.
REQ-020 SHALL update result, cf_out, zf and sf only on that edge; they SHALL NOT change at any other time.
REQ-021 SHALL give latency NSLICE+1 from the start edge to the done cycle: start sampled at edge E0, done=1 during the cycle after edge E(NSLICE).
REQ-022 SHALL hold done=1 only in DONE and busy=1 only in RUN.
REQ-023 SHALL leave DONE after one cycle: to RUN if start=1, else to IDLE; this allows back-to-back operations every NSLICE+1 cycles.
REQ-024 SHALL, with mode=1, compute per bit by sel (0..15): ~a, ~(a|b), ~a&b, all-0, ~(a&b), ~b, a^b, a&~b, ~a|b, ~(a^b), b, a&b, all-1, a|~b, a|b, a.
REQ-025 SHALL force cf_out=0 when mode=1.
REQ-026 SHALL, with mode=0 and carry-in c, compute by sel (0..15): a+c, (a|b)+c, (a|~b)+c, all-1+c, a+(a&~b)+c, (a|b)+(a&~b)+c, a+~b+c, (a&~b)+all-1+c, a+(a&b)+c, a+b+c, (a|~b)+(a&b)+c, (a&b)+all-1+c, a+a+c, (a|b)+a+c, (a|~b)+a+c, a+all-1+c.
REQ-027 SHALL evaluate each arithmetic term per slice, with the all-1 term equal to 8'hFF per slice, so the chained result equals the full DATA_W-bit sum modulo 2^DATA_W.
REQ-028 SHALL set cf_out = carry out of bit DATA_W-1 when mode=0; when a term sums three values, cf_out is the carry out of the final addition, with an internal 9-bit per-slice sum chain.
REQ-029 SHALL set zf = (result == 0) and sf = result[DATA_W-1].

Reset
REQ-030 SHALL, with rst=1 at a rising edge, enter IDLE, clear the slice index and the latched inputs, and set busy=0, done=0, result=0, cf_out=0, zf=1 and sf=0.
REQ-031 SHALL let reset override start and abort any operation in RUN or DONE, with no done pulse and no result update.

Verification
REQ-032 SHALL cover, with DATA_W=16: mode=0, sel=9, a=16'h00FF, b=16'h0001, cf_in=0 -> done in the 3rd cycle after the start edge, result=16'h0100, cf_out=0, zf=0, sf=0.
REQ-033 SHALL cover, with DATA_W=16: mode=0, sel=6, a=16'h0000, b=16'h0001, cf_in=1 -> result=16'hFFFF, cf_out=0, sf=1; same op with a=16'h0005 -> result=16'h0004, cf_out=1.
REQ-034 SHALL cover, with DATA_W=16: mode=1, sel=6, a=16'hF0F0, b=16'hFFFF -> result=16'h0F0F, cf_out=0; and mode=1, sel=3 -> result=0, zf=1.
REQ-035 SHALL cover: start held high continuously -> done pulses every 3 cycles, busy never high in the done cycle, and start pulses during RUN have no effect.
REQ-036 SHALL cover: rst=1 asserted mid-RUN -> busy=0 next cycle, no done pulse, result stays 0.
REQ-037 SHALL cover, with DATA_W=32: mode=0, sel=9, a=32'hFFFFFFFF, b=0, cf_in=1 -> result=0, cf_out=1, zf=1, done 5 cycles after the start edge.
